// File: rtl/umi_pkg.sv
// Shared UMI definitions: EOM bit position, default bus widths and a small
// one-hot helper used by the mux/arbiter slice.
package umi_pkg;

  localparam int UMI_EOM_BIT = 22;
  localparam int UMI_CW      = 32;
  localparam int UMI_AW      = 64;
  localparam int UMI_DW      = 256;

  function automatic logic [3:0] oh2idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++)
      if (oh[i]) idx = idx | 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/umi_mux_arb_if.sv
// Flattened N-way UMI request bundle in, single UMI request bundle out.
interface umi_mux_arb_if #(
  parameter int N  = 4,
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 256
);

  logic [N-1:0]    umi_in_valid;
  logic [N*CW-1:0] umi_in_cmd;
  logic [N*AW-1:0] umi_in_dstaddr;
  logic [N*AW-1:0] umi_in_srcaddr;
  logic [N*DW-1:0] umi_in_data;
  logic [N-1:0]    umi_in_ready;

  logic            umi_out_valid;
  logic [CW-1:0]   umi_out_cmd;
  logic [AW-1:0]   umi_out_dstaddr;
  logic [AW-1:0]   umi_out_srcaddr;
  logic [DW-1:0]   umi_out_data;
  logic            umi_out_ready;

  modport slave (
    input  umi_in_valid, umi_in_cmd, umi_in_dstaddr,
    input  umi_in_srcaddr, umi_in_data,
    output umi_in_ready,
    output umi_out_valid, umi_out_cmd, umi_out_dstaddr,
    output umi_out_srcaddr, umi_out_data,
    input  umi_out_ready
  );

  modport master (
    output umi_in_valid, umi_in_cmd, umi_in_dstaddr,
    output umi_in_srcaddr, umi_in_data,
    input  umi_in_ready,
    input  umi_out_valid, umi_out_cmd, umi_out_dstaddr,
    input  umi_out_srcaddr, umi_out_data,
    output umi_out_ready
  );

endinterface

// File: rtl/umi_rr_arbiter.sv
// Combinational round-robin arbiter with message lock; double-width masked
// priority encode starting at ptr.
module umi_rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          lock,
  input  logic [PW-1:0] lockidx,
  output logic [N-1:0]  grant
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  logic           found;

  always_comb begin
    dbl    = {req, req};
    masked = '0;
    found  = 1'b0;
    grant  = '0;
    for (int j = 0; j < 2*N; j++)
      masked[j] = dbl[j] & (j >= int'(ptr));
    if (lock) begin
      grant[lockidx] = 1'b1;
    end else begin
      for (int j = 0; j < 2*N; j++) begin
        if (masked[j] && !found) begin
          grant[j % N] = 1'b1;
          found        = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/umi_mux_arb.sv
// N:1 UMI request mux with message-locked round-robin arbitration and a
// single registered output stage.
module umi_mux_arb
  import umi_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = UMI_DW,
  parameter int CW = UMI_CW,
  parameter int AW = UMI_AW
) (
  input logic          clk,
  input logic          reset,
  umi_mux_arb_if.slave u
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic          lock_q, lock_d;
  logic [PW-1:0] lockidx_q, lockidx_d;
  logic [PW-1:0] ptr_q, ptr_d;

  logic          valid_q;
  logic [CW-1:0] cmd_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] src_q;
  logic [DW-1:0] data_q;

  logic [N-1:0]  grant;
  logic [PW-1:0] k;
  logic          load;
  logic          acc;
  logic          eom;

  logic [CW-1:0] sel_cmd;
  logic [AW-1:0] sel_dst;
  logic [AW-1:0] sel_src;
  logic [DW-1:0] sel_data;

  umi_rr_arbiter #(.N(N)) u_arb (
    .req     (u.umi_in_valid),
    .ptr     (ptr_q),
    .lock    (lock_q),
    .lockidx (lockidx_q),
    .grant   (grant)
  );

  always_comb begin
    sel_cmd  = '0;
    sel_dst  = '0;
    sel_src  = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      sel_cmd  = sel_cmd  | (u.umi_in_cmd[i*CW+:CW]     & {CW{grant[i]}});
      sel_dst  = sel_dst  | (u.umi_in_dstaddr[i*AW+:AW] & {AW{grant[i]}});
      sel_src  = sel_src  | (u.umi_in_srcaddr[i*AW+:AW] & {AW{grant[i]}});
      sel_data = sel_data | (u.umi_in_data[i*DW+:DW]    & {DW{grant[i]}});
    end
  end

  assign load = ~valid_q | u.umi_out_ready;
  assign acc  = (|(grant & u.umi_in_valid)) & load;
  assign k    = PW'(oh2idx(16'(grant)));
  assign eom  = sel_cmd[UMI_EOM_BIT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q    <= 1'b0;
      lockidx_q <= '0;
      ptr_q     <= '0;
    end else begin
      lock_q    <= lock_d;
      lockidx_q <= lockidx_d;
      ptr_q     <= ptr_d;
    end
  end

  always_comb begin
    lock_d    = lock_q;
    lockidx_d = lockidx_q;
    ptr_d     = ptr_q;
    if (acc) begin
      if (eom) begin
        lock_d = 1'b0;
        ptr_d  = (k == PW'(N-1)) ? '0 : k + PW'(1);
      end else begin
        lock_d    = 1'b1;
        lockidx_d = k;
      end
    end
  end

  // Ready is forced low during reset so no beat is taken from a sender
  // that is itself being reset.
  always_comb begin
    u.umi_in_ready = reset ? '0 : (grant & {N{load}});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      cmd_q   <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= acc;
      if (acc) begin
        cmd_q  <= sel_cmd;
        dst_q  <= sel_dst;
        src_q  <= sel_src;
        data_q <= sel_data;
      end
    end
  end

  assign u.umi_out_valid   = valid_q;
  assign u.umi_out_cmd     = cmd_q;
  assign u.umi_out_dstaddr = dst_q;
  assign u.umi_out_srcaddr = src_q;
  assign u.umi_out_data    = data_q;

endmodule
